// File: rtl/hci_core_mem_rsp_buffer.sv
// rtl/hci_core_mem_rsp_buffer.sv - core/mem HCI bridge with credit-gated issue and response FIFO
// Optional build macro: HCI_RSP_ID_CHECK_EN (compare returned r_id against the issued tag)
// Ports:
//   clk_i, rst_ni                       clock, synchronous active-low reset
//   core_req_i/core_gnt_o               core request handshake
//   core_add_i/wen_i/data_i/be_i        core request payload (passed to mem side)
//   core_lrdy_i                         core accepts the shown response
//   core_r_data_o/r_valid_o/r_opc_o     core response (opc = tag-mismatch flag)
//   mem_req_o/mem_gnt_i                 mem request handshake
//   mem_add_o/wen_o/data_o/be_o/id_o    mem request payload and tag
//   mem_r_data_i/mem_r_id_i             fixed-latency mem response
//   err_o                               sticky tag-mismatch flag
module hci_core_mem_rsp_buffer #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int BW      = 8,
   parameter int IW      = 8,
   parameter int DEPTH   = 4,
   parameter int MEM_LAT = 1
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               core_req_i,
   output logic               core_gnt_o,
   input  logic [AW-1:0]      core_add_i,
   input  logic               core_wen_i,
   input  logic [DW-1:0]      core_data_i,
   input  logic [DW/BW-1:0]   core_be_i,
   input  logic               core_lrdy_i,
   output logic [DW-1:0]      core_r_data_o,
   output logic               core_r_valid_o,
   output logic               core_r_opc_o,
   output logic               mem_req_o,
   input  logic               mem_gnt_i,
   output logic [AW-1:0]      mem_add_o,
   output logic               mem_wen_o,
   output logic [DW-1:0]      mem_data_o,
   output logic [DW/BW-1:0]   mem_be_o,
   output logic [IW-1:0]      mem_id_o,
   input  logic [DW-1:0]      mem_r_data_i,
   input  logic [IW-1:0]      mem_r_id_i,
   output logic               err_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1) + 1;

   logic [CW-1:0]      inflight_q;
   logic [CW-1:0]      fifo_cnt_q;
   logic [PW-1:0]      wr_ptr_q;
   logic [PW-1:0]      rd_ptr_q;
   logic [IW-1:0]      tag_q;
   logic [MEM_LAT-1:0] pipe_vld_q;
   logic [DW-1:0]      fifo_data_q [DEPTH];
   logic               fifo_opc_q  [DEPTH];

   logic credit_ok;
   logic handshake;
   logic arrival;
   logic arr_opc;
   logic fifo_empty;
   logic fifo_full;
   logic push;
   logic pop;

   // Everything issued but not yet consumed by the core holds a credit, so an
   // arrival always finds a free FIFO slot even under a long lrdy stall.
   assign credit_ok  = (inflight_q + fifo_cnt_q) < CW'(DEPTH);
   assign mem_req_o  = core_req_i & credit_ok;
   assign core_gnt_o = mem_gnt_i & credit_ok;
   assign handshake  = mem_req_o & mem_gnt_i;

   assign mem_add_o  = core_add_i;
   assign mem_wen_o  = core_wen_i;
   assign mem_data_o = core_data_i;
   assign mem_be_o   = core_be_i;
   assign mem_id_o   = tag_q;

   assign arrival    = pipe_vld_q[MEM_LAT-1];
   assign fifo_empty = (fifo_cnt_q == '0);
   assign fifo_full  = (fifo_cnt_q == CW'(DEPTH));

   // Fall-through: an arrival into an empty FIFO bypasses storage when the
   // core is ready; otherwise it queues behind whatever is already held.
   assign push = arrival & ~(fifo_empty & core_lrdy_i);
   assign pop  = ~fifo_empty & core_lrdy_i;

   always_comb begin
      core_r_valid_o = ~fifo_empty | arrival;
      core_r_data_o  = '0;
      core_r_opc_o   = 1'b0;
      if (!fifo_empty) begin
         core_r_data_o = fifo_data_q[rd_ptr_q];
         core_r_opc_o  = fifo_opc_q[rd_ptr_q];
      end else if (arrival) begin
         core_r_data_o = mem_r_data_i;
         core_r_opc_o  = arr_opc;
      end
   end

`ifdef HCI_RSP_ID_CHECK_EN
   logic [IW-1:0] pipe_tag_q [MEM_LAT];
   logic          err_q;

   assign arr_opc = arrival & (mem_r_id_i != pipe_tag_q[MEM_LAT-1]);
   assign err_o   = err_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         err_q <= 1'b0;
         for (int i = 0; i < MEM_LAT; i++) pipe_tag_q[i] <= '0;
      end else begin
         err_q         <= err_q | arr_opc;
         pipe_tag_q[0] <= tag_q;
         for (int i = 1; i < MEM_LAT; i++) pipe_tag_q[i] <= pipe_tag_q[i-1];
      end
   end
`else
   logic unused_r_id;

   assign arr_opc     = 1'b0;
   assign err_o       = 1'b0;
   assign unused_r_id = ^mem_r_id_i;
`endif

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         inflight_q <= '0;
         fifo_cnt_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         tag_q      <= '0;
         pipe_vld_q <= '0;
      end else begin
         pipe_vld_q[0] <= handshake;
         for (int i = 1; i < MEM_LAT; i++) pipe_vld_q[i] <= pipe_vld_q[i-1];

         if (handshake) tag_q <= tag_q + IW'(1);

         if (handshake && !arrival)      inflight_q <= inflight_q + CW'(1);
         else if (!handshake && arrival) inflight_q <= inflight_q - CW'(1);

         if (push && !pop)      fifo_cnt_q <= fifo_cnt_q + CW'(1);
         else if (pop && !push) fifo_cnt_q <= fifo_cnt_q - CW'(1);

         if (push) begin
            fifo_data_q[wr_ptr_q] <= mem_r_data_i;
            fifo_opc_q[wr_ptr_q]  <= arr_opc;
            wr_ptr_q <= (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_q <= (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
         end
      end
   end

   a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && fifo_full));

endmodule

// File: tb/tb_hci_core_mem_rsp_buffer.sv
// tb/tb_hci_core_mem_rsp_buffer.sv - scoreboard bench for hci_core_mem_rsp_buffer
module tb_hci_core_mem_rsp_buffer;
   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int BW    = 8;
   localparam int IW    = 2;
   localparam int DEPTH = 4;
`ifdef HCI_RSP_ID_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   logic            clk_i = 1'b0;
   logic            rst_ni = 1'b0;
   logic            core_req_i = 1'b0;
   logic            core_gnt_o;
   logic [AW-1:0]   core_add_i = '0;
   logic            core_wen_i = 1'b0;
   logic [DW-1:0]   core_data_i = '0;
   logic [DW/BW-1:0] core_be_i = '0;
   logic            core_lrdy_i = 1'b0;
   logic [DW-1:0]   core_r_data_o;
   logic            core_r_valid_o;
   logic            core_r_opc_o;
   logic            mem_req_o;
   logic            mem_gnt_i = 1'b0;
   logic [AW-1:0]   mem_add_o;
   logic            mem_wen_o;
   logic [DW-1:0]   mem_data_o;
   logic [DW/BW-1:0] mem_be_o;
   logic [IW-1:0]   mem_id_o;
   logic [DW-1:0]   mem_r_data_i = '0;
   logic [IW-1:0]   mem_r_id_i = '0;
   logic            err_o;

   hci_core_mem_rsp_buffer #(
      .AW(AW), .DW(DW), .BW(BW), .IW(IW), .DEPTH(DEPTH), .MEM_LAT(1)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .core_req_i(core_req_i), .core_gnt_o(core_gnt_o), .core_add_i(core_add_i),
      .core_wen_i(core_wen_i), .core_data_i(core_data_i), .core_be_i(core_be_i),
      .core_lrdy_i(core_lrdy_i), .core_r_data_o(core_r_data_o),
      .core_r_valid_o(core_r_valid_o), .core_r_opc_o(core_r_opc_o),
      .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_add_o(mem_add_o),
      .mem_wen_o(mem_wen_o), .mem_data_o(mem_data_o), .mem_be_o(mem_be_o),
      .mem_id_o(mem_id_o), .mem_r_data_i(mem_r_data_i), .mem_r_id_i(mem_r_id_i),
      .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   int total = 0;
   int bad = 0;
   logic [DW-1:0] exp_data_q [$];
   logic          exp_opc_q  [$];
   int            outstanding = 0;
   int            n_hs = 0;
   int            n_pop = 0;
   int            corrupt_at = -1;
   logic [IW-1:0] exp_tag = '0;
   bit            stall_q = 1'b0;
   logic [DW-1:0] stall_data = '0;
   logic          stall_opc = 1'b0;

   // One clock cycle: called at the negedge with this cycle's inputs applied.
   task automatic tick();
      bit            credit, hs, pop, cor;
      logic [DW-1:0] d;
      logic [IW-1:0] id;
      logic [DW-1:0] got_d;
      logic          got_o;
      d = '0; id = '0; cor = 1'b0;
      #1;
      credit = (outstanding < DEPTH);
      total++;
      if (core_gnt_o !== (mem_gnt_i & credit))
         begin bad++; $display("FAIL core_gnt: got %b want %b", core_gnt_o, mem_gnt_i & credit); end
      total++;
      if (mem_req_o !== (core_req_i & credit))
         begin bad++; $display("FAIL mem_req: got %b want %b", mem_req_o, core_req_i & credit); end
      if (stall_q) begin
         total++;
         if (core_r_valid_o !== 1'b1 || core_r_data_o !== stall_data || core_r_opc_o !== stall_opc) begin
            bad++;
            $display("FAIL hold: got v=%b d=%h o=%b want v=1 d=%h o=%b",
                     core_r_valid_o, core_r_data_o, core_r_opc_o, stall_data, stall_opc);
         end
      end
      stall_q    = core_r_valid_o & ~core_lrdy_i;
      stall_data = core_r_data_o;
      stall_opc  = core_r_opc_o;
      hs  = mem_req_o & mem_gnt_i;
      pop = core_r_valid_o & core_lrdy_i;
      if (hs) begin
         total++;
         if (mem_id_o !== exp_tag)
            begin bad++; $display("FAIL mem_id: got %0d want %0d", mem_id_o, exp_tag); end
         total++;
         if ({mem_add_o, mem_wen_o, mem_data_o, mem_be_o} !== {core_add_i, core_wen_i, core_data_i, core_be_i})
            begin bad++; $display("FAIL payload: got %h want %h", mem_add_o, core_add_i); end
         cor = (n_hs == corrupt_at);
         d   = $urandom;
         id  = cor ? (exp_tag ^ IW'(1)) : exp_tag;
         exp_data_q.push_back(d);
         exp_opc_q.push_back(cor & CHECK_EN);
         exp_tag = exp_tag + IW'(1);
         n_hs++;
         outstanding++;
      end
      if (pop) begin
         total++;
         if (exp_data_q.size() == 0) begin
            bad++; $display("FAIL rsp_extra: got d=%h want no response", core_r_data_o);
         end else begin
            got_d = exp_data_q.pop_front();
            got_o = exp_opc_q.pop_front();
            if (core_r_data_o !== got_d || core_r_opc_o !== got_o) begin
               bad++;
               $display("FAIL rsp: got d=%h o=%b want d=%h o=%b", core_r_data_o, core_r_opc_o, got_d, got_o);
            end
         end
         outstanding--;
         n_pop++;
      end
      @(posedge clk_i);
      #1;
      mem_r_data_i = hs ? d : DW'($urandom);
      mem_r_id_i   = hs ? id : IW'($urandom);
      core_add_i   = $urandom;
      core_wen_i   = 1'($urandom);
      core_data_i  = $urandom;
      core_be_i    = 4'($urandom);
      @(negedge clk_i);
   endtask

   task automatic apply_reset();
      rst_ni = 1'b0; core_req_i = 1'b0; core_lrdy_i = 1'b0; mem_gnt_i = 1'b0;
      @(posedge clk_i);
      #1;
      exp_data_q.delete(); exp_opc_q.delete();
      outstanding = 0; exp_tag = '0; stall_q = 1'b0; corrupt_at = -1;
      @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   task automatic drain();
      int cyc;
      core_req_i = 1'b0; core_lrdy_i = 1'b1;
      cyc = 0;
      while (outstanding > 0 && cyc < 40) begin tick(); cyc++; end
      total++;
      if (outstanding != 0 || exp_data_q.size() != 0)
         begin bad++; $display("FAIL drain_timeout: got %0d outstanding want 0", outstanding); end
   endtask

   task automatic test_reset();
      apply_reset();
      #1;
      total++; if (core_r_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", core_r_valid_o); end
      total++; if (core_r_data_o !== '0) begin bad++; $display("FAIL rst_data: got %h want 0", core_r_data_o); end
      total++; if (core_r_opc_o !== 1'b0) begin bad++; $display("FAIL rst_opc: got %b want 0", core_r_opc_o); end
      total++; if (err_o !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", err_o); end
      total++; if (mem_id_o !== '0) begin bad++; $display("FAIL rst_tag: got %0d want 0", mem_id_o); end
      @(negedge clk_i);
   endtask

   task automatic test_back_to_back();
      int p0;
      p0 = n_pop;
      core_lrdy_i = 1'b1; core_req_i = 1'b1; mem_gnt_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) begin
            #1; total++;
            if (core_r_valid_o !== 1'b1) begin bad++; $display("FAIL b2b_valid%0d: got %b want 1", i, core_r_valid_o); end
         end
         tick();
      end
      core_req_i = 1'b0;
      #1; total++;
      if (core_r_valid_o !== 1'b1) begin bad++; $display("FAIL b2b_last_valid: got %b want 1", core_r_valid_o); end
      drain();
      total++;
      if (n_pop - p0 != 8) begin bad++; $display("FAIL b2b_count: got %0d want 8", n_pop - p0); end
   endtask

   task automatic test_credit_stall();
      int h0, cyc;
      h0 = n_hs;
      core_lrdy_i = 1'b0; core_req_i = 1'b1; mem_gnt_i = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      total++;
      if (n_hs - h0 != DEPTH) begin bad++; $display("FAIL stall_grants: got %0d want %0d", n_hs - h0, DEPTH); end
      #1; total++;
      if (core_gnt_o !== 1'b0) begin bad++; $display("FAIL stall_gnt: got %b want 0", core_gnt_o); end
      core_lrdy_i = 1'b1;
      cyc = 0;
      while (n_hs - h0 < 6 && cyc < 30) begin tick(); cyc++; end
      total++;
      if (n_hs - h0 != 6) begin bad++; $display("FAIL stall_resume: got %0d want 6", n_hs - h0); end
      drain();
   endtask

   task automatic test_gnt_toggle();
      int h0;
      h0 = n_hs;
      core_req_i = 1'b1; core_lrdy_i = 1'b1;
      for (int i = 0; i < 16; i++) begin mem_gnt_i = (i % 2 == 0); tick(); end
      total++;
      if (n_hs - h0 != 8) begin bad++; $display("FAIL toggle_grants: got %0d want 8", n_hs - h0); end
      for (int i = 0; i < 24; i++) begin
         mem_gnt_i = 1'($urandom); core_lrdy_i = 1'($urandom); tick();
      end
      drain();
   endtask

   task automatic test_tag_wrap();
      core_req_i = 1'b1; mem_gnt_i = 1'b1; core_lrdy_i = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      drain();
      total++;
      if (err_o !== 1'b0) begin bad++; $display("FAIL wrap_err: got %b want 0", err_o); end
   endtask

   task automatic test_id_corrupt();
      corrupt_at = n_hs + 2;
      core_req_i = 1'b1; mem_gnt_i = 1'b1; core_lrdy_i = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      drain();
      total++;
      if (err_o !== CHECK_EN) begin bad++; $display("FAIL corrupt_err: got %b want %b", err_o, CHECK_EN); end
      corrupt_at = -1;
      core_req_i = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      drain();
      total++;
      if (err_o !== CHECK_EN) begin bad++; $display("FAIL err_sticky: got %b want %b", err_o, CHECK_EN); end
   endtask

   task automatic test_reset_inflight();
      int h0;
      core_lrdy_i = 1'b0; core_req_i = 1'b1; mem_gnt_i = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      apply_reset();
      #1;
      total++; if (core_r_valid_o !== 1'b0) begin bad++; $display("FAIL rst2_valid: got %b want 0", core_r_valid_o); end
      total++; if (mem_id_o !== '0) begin bad++; $display("FAIL rst2_tag: got %0d want 0", mem_id_o); end
      total++; if (err_o !== 1'b0) begin bad++; $display("FAIL rst2_err: got %b want 0", err_o); end
      @(negedge clk_i);
      h0 = n_hs;
      core_lrdy_i = 1'b0; core_req_i = 1'b1; mem_gnt_i = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      total++;
      if (n_hs - h0 != DEPTH) begin bad++; $display("FAIL rst2_credit: got %0d want %0d", n_hs - h0, DEPTH); end
      drain();
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_credit_stall();
      test_gnt_toggle();
      test_tag_wrap();
      test_id_corrupt();
      test_reset_inflight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end
endmodule
